// File: rtl/alu_logic_sequencer.sv
// -----------------------------------------------------------------------------
// alu_logic_sequencer
//
// Initiator for an external 8-bit combinational logic unit (A, B, S -> Out).
// A command is accepted over a valid/ready port. Its operands and select are
// registered onto alu_a/alu_b/alu_s. After SETTLE_CYCLES clocks the unit's
// result is captured and returned over a valid/ready response port. The last
// captured result is kept in an accumulator. A later command can use it as
// operand A by setting cmd_acc.
//
// Parameters
//   WIDTH          operand/result width; must match the logic unit
//   SETTLE_CYCLES  clocks between driving alu_a/b/s and capturing alu_out (1..15)
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_a, cmd_b               operands (cmd_a ignored when cmd_acc=1)
//   cmd_op                     00 AND, 01 OR, 10 XOR, 11 NOT A
//   cmd_acc                    use accumulator as operand A
//   alu_a, alu_b, alu_s        registered drive to the logic unit
//   alu_out                    logic unit result
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_zero         captured result and its zero flag
//   rsp_parity                 ^result, only when ALU_SEQ_PARITY_EN is defined
//
// Build option
//   ALU_SEQ_PARITY_EN : adds the rsp_parity output and its register.
// -----------------------------------------------------------------------------
module alu_logic_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_SEQ_PARITY_EN
    output logic             rsp_parity,
`endif
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // The counter is loaded with SETTLE_CYCLES-1. The capture happens on the
    // edge where it reads zero. That edge is SETTLE_CYCLES clocks after the
    // accept edge.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] acc;

    logic             accept;
    logic             capture;
    logic             handoff;
    logic [WIDTH-1:0] opa_sel;

    // Next-state and handshake decode
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        handoff   = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // No command is accepted on the edge that retires the
                // response. The next accept happens one cycle later.
                if (rsp_ready) begin
                    handoff   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign opa_sel = cmd_acc ? acc : cmd_a;

    // State register and settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= CNT_INIT;
            end else if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Logic-unit drive. These registers load only on accept, so the unit
    // sees steady inputs while the sequencer waits or holds a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_s <= 2'b00;
        end else if (accept) begin
            alu_a <= opa_sel;
            alu_b <= cmd_b;
            alu_s <= cmd_op;
        end
    end

    // Result capture and response handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_zero  <= 1'b1;
            acc       <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (capture) begin
                rsp_data  <= alu_out;
                rsp_zero  <= (alu_out == '0);
                acc       <= alu_out;
                rsp_valid <= 1'b1;
            end else if (handoff) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_PARITY_EN
    // Parity is registered on the same edge as rsp_data. It is valid under
    // the same conditions as rsp_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_parity <= 1'b0;
        end else if (capture) begin
            rsp_parity <= ^alu_out;
        end
    end
`endif

endmodule

// File: tb/tb_alu_logic_sequencer.sv
module tb_alu_logic_sequencer;

    localparam int W      = 8;
    localparam int SETTLE = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [1:0]   cmd_op;
    logic         cmd_acc;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_s;
    logic [W-1:0] alu_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_zero;
`ifdef ALU_SEQ_PARITY_EN
    logic         rsp_parity;
`endif

    always #5 clk = ~clk;

    alu_logic_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .cmd_acc   (cmd_acc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef ALU_SEQ_PARITY_EN
        .rsp_parity(rsp_parity),
`endif
        .rsp_zero  (rsp_zero)
    );

    // External combinational logic unit
    always_comb begin
        alu_out = '0;
        case (alu_s)
            2'b00: alu_out = alu_a & alu_b;
            2'b01: alu_out = alu_a | alu_b;
            2'b10: alu_out = alu_a ^ alu_b;
            default: alu_out = ~alu_a;
        endcase
    end

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] opa;
        logic [W-1:0] opb;
        logic [1:0]   op;
        int           acc_edge;
    } exp_t;

    exp_t         q[$];
    int           n_vec  = 0;
    int           n_fail = 0;
    int           cyc    = 0;
    logic [W-1:0] model_acc;
    int           bp_req  = 0;
    logic         rand_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model. Each result bit is derived from the count of ones in
    // the operand bit pair.
    function automatic logic [W-1:0] ref_result(input logic [1:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [W-1:0] r;
        int ones;
        r = '0;
        for (int i = 0; i < W; i++) begin
            ones = int'(a[i]) + int'(b[i]);
            case (op)
                2'd0: r[i] = (ones == 2);
                2'd1: r[i] = (ones >= 1);
                2'd2: r[i] = (ones == 1);
                default: r[i] = (a[i] == 1'b0);
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic use_acc);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_acc = use_acc; cmd_valid = 1'b1;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        e.opa      = use_acc ? model_acc : a;
        e.opb      = b;
        e.op       = op;
        e.data     = ref_result(op, e.opa, b);
        e.acc_edge = cyc + 1;
        model_acc  = e.data;
        q.push_back(e);
        @(posedge clk);
        #1;
        // Scramble the command bus after the accept edge. The pending
        // operation must not change.
        cmd_valid = 1'b0;
        cmd_a = W'($urandom); cmd_b = W'($urandom);
        cmd_op = 2'($urandom); cmd_acc = 1'($urandom);
    endtask

    // Response consumer with optional random and forced backpressure
    initial begin
        int hold = 0;
        int seen = 0;
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_req != seen) begin
                seen = bp_req;
                hold = SETTLE + 6;
            end
            if (hold > 0) begin
                rsp_ready = 1'b0;
                hold--;
            end else begin
                rsp_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic prev_valid = 1'b0;
        logic prev_hs    = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_rsp_data",  32'(rsp_data),  32'd0);
                chk("rst_rsp_zero",  32'(rsp_zero),  32'd1);
                chk("rst_alu_s",     32'(alu_s),     32'd0);
                chk("rst_alu_a",     32'(alu_a),     32'd0);
`ifdef ALU_SEQ_PARITY_EN
                chk("rst_parity",    32'(rsp_parity), 32'd0);
`endif
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
                continue;
            end
            if (prev_hs) begin
                chk("valid_drop", 32'(rsp_valid), 32'd0);
                chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
            end
            if (rsp_valid) begin
                chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = q[0];
                    if (!prev_valid) begin
                        chk("latency", 32'(cyc - e.acc_edge), 32'(SETTLE));
                        chk("alu_a", 32'(alu_a), 32'(e.opa));
                        chk("alu_b", 32'(alu_b), 32'(e.opb));
                        chk("alu_s", 32'(alu_s), 32'(e.op));
                    end
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.data == '0));
`ifdef ALU_SEQ_PARITY_EN
                    chk("rsp_parity", 32'(rsp_parity), 32'(^e.data));
`endif
                    if (rsp_ready) void'(q.pop_front());
                end
            end
            prev_valid = rsp_valid;
            prev_hs    = rsp_valid && rsp_ready;
        end
    end

    // Stimulus
    initial begin
        int waited;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_acc = 1'b0;
        model_acc = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed cases
        issue(8'hF0, 8'h3C, 2'b00, 1'b0);   // 30
        issue(8'hAA, 8'hAA, 2'b10, 1'b0);   // 00, zero
        issue(8'h0F, 8'h55, 2'b11, 1'b0);   // F0
        issue(8'h0F, 8'hF0, 2'b01, 1'b0);   // FF
        issue(8'h12, 8'h3C, 2'b00, 1'b1);   // acc FF & 3C = 3C
        issue(8'h07, 8'h00, 2'b01, 1'b0);   // 07, odd parity
        issue(8'h03, 8'h00, 2'b01, 1'b0);   // 03, even parity

        // Forced backpressure while a response is pending
        bp_req++;
        issue(8'hC3, 8'h5A, 2'b10, 1'b0);
        issue(8'h01, 8'h80, 2'b01, 1'b1);

        // Reset in the middle of SETTLE discards the operation
        issue(8'h99, 8'h66, 2'b01, 1'b0);
        #1 rst_n = 1'b0;
        q.delete();
        model_acc = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        issue(8'hFF, 8'h3C, 2'b01, 1'b1);   // acc cleared: 00 | 3C

        // Randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(W'($urandom), W'($urandom), 2'($urandom),
                  ($urandom_range(0, 2) == 0));
        end

        waited = 0;
        while (q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_queue", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
